// File: rtl/regfile_pkg.sv
// Shared register-file constants: index/data widths, the hard-wired zero
// register and the fixed requester slots of the write-back arbiter.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  localparam int WB_ALU = 0;
  localparam int WB_MEM = 1;
  localparam int WB_DBG = 2;

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin priority search over a request vector, with the rotating
// start pointer kept here so the search and its bookkeeping stay together.
module rr_arbiter_core #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_idx,
  output logic               grant_valid
);

  logic [2:0] ptr;
  logic       hi_found;
  logic [2:0] hi_idx;
  logic       lo_found;
  logic [2:0] lo_idx;

  // Lowest request at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 3'd0;
    lo_found = 1'b0;
    lo_idx   = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = 3'(i);
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = 3'(i);
        end
      end
    end
    grant_valid = lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
    grant       = lo_found ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 3'd0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port among several write-back
// producers; the winning write is registered onto the port, $0 writes dropped.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         writeRegister,
  output logic [DATA_W-1:0]         writeData,
  output logic                      writeEnable,
  output logic                      wb_pending,
  output logic [2:0]                grant_id
);

  logic               arb_en;
  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         grant_idx;
  logic               grant_valid;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;

  // Masking requests here keeps both the grant and the pointer frozen.
  assign arb_en     = !stall && !rst;
  assign req_masked = req_valid & {NUM_REQ{arb_en}};

  rr_arbiter_core #(
    .NUM_REQ(NUM_REQ)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .req         (req_masked),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;

  // One-hot select keeps req_reg/req_data off the req_ready path.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      writeEnable   <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      grant_id      <= 3'd0;
    end else if (grant_valid) begin
      writeEnable   <= (sel_reg != ADDR_W'(ZERO_REG));
      writeRegister <= sel_reg;
      writeData     <= sel_data;
      grant_id      <= grant_idx;
    end else begin
      writeEnable   <= 1'b0;
    end
  end

  assign wb_pending = writeEnable;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file in the multicycle datapath. The register file has one write port, but several producers need it: ALU result write-back, load write-back and the debug/monitor poke port. This block shares that port among `NUM_REQ` requesters using a valid/ready handshake and round-robin fairness. It registers the winning write onto the register-file write port, discards writes to `$0`, and freezes under a pipeline stall.

## Interface
- `NUM_REQ`, default 3: number of write requesters (2..8).
- `ADDR_W`, default 5: register index width.
- `DATA_W`, default 32: write data width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high; clock `clk`.
- `stall`  in  1  when high, no grants are issued and the pointer is frozen.
- `req_valid`  in  `NUM_REQ`  per-requester write request.
- `req_reg`  in  `NUM_REQ*ADDR_W`  destination index; requester i owns bits [i*ADDR_W +: ADDR_W].
- `req_data`  in  `NUM_REQ*DATA_W`  write data, packed the same way.
- `req_ready`  out  `NUM_REQ`  grant, one-hot or zero, combinational.
- `writeRegister`  out  `ADDR_W`  to the register-file write index (registered).
- `writeData`  out  `DATA_W`  to the register-file write data (registered).
- `writeEnable`  out  1  to the register-file write enable (registered).
- `wb_pending`  out  1  high while a granted write sits in the output register (equals `writeEnable`).
- `grant_id`  out  3  index of the last granted requester (registered).

## Operation
- Handshake: a transfer for requester i occurs on a rising edge when `req_valid[i] && req_ready[i]`.
- Requester obligation: hold `req_reg`/`req_data` stable while valid is high and not yet granted.
- Arbitration, each cycle with `!stall && !rst`:
  - Search `req_valid` starting at pointer `ptr` and wrapping at `NUM_REQ-1` to 0.
  - The first valid requester gets `req_ready`; at most one bit is set.
- Pointer update:
  - After a grant to i, `ptr <= (i+1) mod NUM_REQ`.
  - With no grant, `ptr` is unchanged.
  - Fairness bound: a continuously valid requester waits at most `NUM_REQ-1` grants.
- Output register, on a handshake from requester i:
  - `writeRegister <= req_reg[i]`, `writeData <= req_data[i]`, `grant_id <= i`.
  - `writeEnable <= (req_reg[i] != 0)`.
- `$0` writes are accepted and consumed, but `writeEnable` stays 0. `writeRegister`/`writeData` still update.
- No handshake: `writeEnable <= 0`; `writeRegister`, `writeData` and `grant_id` hold their values.
- Stall: `req_ready` is all 0, `writeEnable <= 0`, `ptr` is frozen. Pending valid requests persist and are granted after the stall drops, in normal pointer order.
- No internal buffering beyond the single output register. The arbiter accepts one write per cycle, every cycle.

## Timing
- `req_ready` is combinational from `req_valid`, `stall` and `ptr`. It has no path from `req_data`/`req_reg`.
- Latency:
  - Handshake at edge E puts `writeEnable`/`writeRegister`/`writeData` valid during cycle E..E+1.
  - The register-file array is updated at edge E+1.
  - The write is visible on register-file read data after a read issued at edge E+2 or later.
- Throughput: one write per cycle.
- Reset: on `rst` at an edge, `ptr <= 0`, `writeEnable <= 0`, `writeRegister <= 0`, `writeData <= 0`, `grant_id <= 0`.
  - While `rst` is high, `req_ready` is forced to 0.
  - A write granted the cycle before reset still reaches the register file. The register file's own reset wins in that same cycle.
- Simultaneous `stall` and `rst`: `rst` dominates.
- Changing `NUM_REQ` changes only the search width. Pointer wrap is at `NUM_REQ-1`; `ptr` is never ≥ `NUM_REQ`.

## Structure
- Shared package `regfile_pkg`: `REG_ADDR_W=5`, `REG_DATA_W=32`, `ZERO_REG=5'd0`, requester index constants `WB_ALU=0`, `WB_MEM=1`, `WB_DBG=2`.
- Sub-module `rr_arbiter_core`: combinational rotate/priority search plus the registered `ptr`, generic in `NUM_REQ`. It outputs the one-hot grant and the encoded index. The top level adds the data mux, `$0` filter, stall gating and output register.

## Test plan
- Reset: assert `rst` 2 cycles with all `req_valid`=1.
  - Required: `req_ready`=0 throughout.
  - Required after reset: `writeEnable`=0, `writeRegister`=0, `writeData`=0, `grant_id`=0.
- Single write: req1 valid, reg 7, data 0xDEADBEEF.
  - Required: `req_ready`=3'b010 in the same cycle.
  - Required next cycle: `writeEnable`=1, `writeRegister`=7, `writeData`=0xDEADBEEF.
  - Required the cycle after: `writeEnable`=0.
- Round-robin: all 3 requesters valid for 6 cycles with distinct regs 1/2/3.
  - Required: grant order 0,1,2,0,1,2.
  - Required: `writeEnable` high every cycle after the first.
- `$0` discard: req0 valid, reg 0, data 0x12345678.
  - Required: handshake completes and `writeEnable` stays 0.
  - Required: `grant_id`=0.
- Stall: req2 valid with stall=1 for 3 cycles, then stall=0.
  - Required: no `req_ready` during the stall; grant to req2 on the first unstalled cycle.
  - Required: `ptr` is unchanged across the stall.
- Reset mid-stream: all valid, assert `rst` after the grant to req1.
  - Required: the next post-reset grant goes to req0.
  - Required: `writeEnable`=0 on the cycle after the reset edge.
